fd_reg: RTL



---
 rtl/fd_reg_pkg.sv | 9 +
 rtl/fd_reg_fetch_chk.sv | 11 +
 rtl/fd_reg.sv | 61 ++++++
 3 files changed

// File: rtl/fd_reg_pkg.sv
// fd_reg_pkg: exception codes and memory-map defaults shared by the IFU, the F/D register and CP0
package fd_reg_pkg;
    localparam logic [4:0]  EXC_NONE       = 5'd0;
    localparam logic [4:0]  EXC_ADEL       = 5'd4;
    localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
    localparam logic [31:0] IM_LO_DEF      = 32'h0000_3000;
    localparam logic [31:0] IM_HI_DEF      = 32'h0000_6FFC;
    localparam logic [31:0] HANDLER_PC_DEF = 32'h0000_4180;
endpackage

// File: rtl/fd_reg_fetch_chk.sv
// fetch_chk: flags a fetch address that is misaligned or outside instruction memory
// Ports: pc (fetch address in), fetch_err (fault flag out)
module fetch_chk #(
    parameter logic [31:0] IM_LO = 32'h0000_3000,
    parameter logic [31:0] IM_HI = 32'h0000_6FFC
) (
    input  logic [31:0] pc,
    output logic        fetch_err
);
    assign fetch_err = (pc[1:0] != 2'b00) || (pc < IM_LO) || (pc > IM_HI);
endmodule

// File: rtl/fd_reg.sv
// fd_reg: F-to-D pipeline register with fetch-fault tagging, flush on exception/eret, and stall hold
// Ports: clk, reset (sync, active-high); stall, req, eretD, EPC control the update;
//        F_pc/F_instr/F_bd are the fetched inputs; D_* are the registered decode-stage outputs.
module fd_reg
    import fd_reg_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [31:0] IM_LO      = IM_LO_DEF,
    parameter logic [31:0] IM_HI      = IM_HI_DEF,
    parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        req,
    input  logic        eretD,
    input  logic [31:0] EPC,
    input  logic [31:0] F_pc,
    input  logic [31:0] F_instr,
    input  logic        F_bd,
    output logic [31:0] D_instr,
    output logic [31:0] D_pc,
    output logic [31:0] D_pcPlus4,
    output logic [4:0]  D_excCode,
    output logic        D_bd
);
    logic        fetch_err;
    logic        flush;
    logic [31:0] pc_d, pc_q, instr_d, instr_q;
    logic [4:0]  exc_d, exc_q;
    logic        bd_d, bd_q;

    fetch_chk #(.IM_LO(IM_LO), .IM_HI(IM_HI)) u_fetch_chk (
        .pc        (F_pc),
        .fetch_err (fetch_err)
    );

    // reset, req and eret all clear the payload; only the PC they load differs
    assign flush = reset || req || eretD;

    always_comb begin
        pc_d    = reset ? RESET_PC : req ? HANDLER_PC : eretD ? EPC : stall ? pc_q : F_pc;
        // a faulting fetch keeps its true PC but carries a squashed instruction and AdEL
        instr_d = flush ? 32'h0 : stall ? instr_q : fetch_err ? 32'h0 : F_instr;
        exc_d   = flush ? EXC_NONE : stall ? exc_q : fetch_err ? EXC_ADEL : EXC_NONE;
        bd_d    = flush ? 1'b0 : stall ? bd_q : F_bd;
    end

    always_ff @(posedge clk) begin
        pc_q    <= pc_d;
        instr_q <= instr_d;
        exc_q   <= exc_d;
        bd_q    <= bd_d;
    end

    assign D_pc      = pc_q;
    assign D_instr   = instr_q;
    assign D_excCode = exc_q;
    assign D_bd      = bd_q;
    assign D_pcPlus4 = pc_q + 32'd4;
endmodule
